// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory
// with fixed read latency MEM_LAT; round-robin on ties, one transaction at a time.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    input  logic        DM_REQ,
    input  logic        DM_WE,
    input  logic [31:0] DM_ADDR,
    input  logic [31:0] DM_WDATA,
    output logic        DM_ACK,
    output logic [31:0] DM_RDATA,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WR,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] MEM_DOUT,
    output logic        BUSY,
    output logic [1:0]  ARB_ESTADO
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic GntIf = 1'b0;
    localparam logic GntDm = 1'b1;
    localparam logic [2:0] WaitLoad = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        capture;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        capture    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (IF_REQ || DM_REQ) begin
                    // On a tie the port not granted last wins; otherwise the lone requester.
                    if (IF_REQ && DM_REQ) gnt_d = ~last_gnt_q;
                    else                  gnt_d = DM_REQ ? GntDm : GntIf;
                    last_gnt_d = gnt_d;
                    addr_d     = (gnt_d == GntDm) ? DM_ADDR : IF_ADDR;
                    we_d       = (gnt_d == GntDm) && DM_WE;
                    wdata_d    = DM_WDATA;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d = StDone;
                end else if (MEM_LAT == 1) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = WaitLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            if (gnt_q == GntDm) dm_rdata_d = MEM_DOUT;
            else                if_rdata_d = MEM_DOUT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            gnt_q      <= GntIf;
            last_gnt_q <= GntDm;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            cnt_q      <= 3'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign IF_ACK     = (state_q == StDone) && (gnt_q == GntIf);
    assign DM_ACK     = (state_q == StDone) && (gnt_q == GntDm);
    assign IF_RDATA   = if_rdata_q;
    assign DM_RDATA   = dm_rdata_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_DIN    = wdata_q;
    // Masked by RESET so a reset cycle can never commit a store.
    assign MEM_WR     = (state_q == StAccess) && we_q && !RESET;
    assign BUSY       = (state_q != StIdle);
    assign ARB_ESTADO = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 2, 7) each behind a latency-modelled
// memory; directed table, corner-case sequences and a randomized transaction-level model.
module tb_mem_arbiter;

    function automatic int unsigned lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
    endfunction

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a == 32'h4) ? 32'h00A00093 : (32'hC0DE0000 | a);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        env_clr;
    logic        if_req [3];
    logic        dm_req [3];
    logic        dm_we [3];
    logic [31:0] if_addr [3];
    logic [31:0] dm_addr [3];
    logic [31:0] dm_wdata [3];
    logic [31:0] mem_dout [3];
    logic        if_ack [3];
    logic        dm_ack [3];
    logic        mem_wr [3];
    logic        busy [3];
    logic [31:0] if_rdata [3];
    logic [31:0] dm_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_din [3];
    logic [1:0]  estado [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PIX = (lat_of(g) > 1) ? int'(lat_of(g)) - 2 : 0;
        logic [31:0] pipe [6];
        logic [31:0] env_mem [64];
        logic        env_vld [64];
        logic [31:0] rd_now;

        always_comb rd_now = env_vld[mem_addr[g][7:2]] ? env_mem[mem_addr[g][7:2]]
                                                       : dflt(mem_addr[g]);

        // Read data emerges MEM_LAT cycles after the address is first presented.
        always @(posedge clk) begin
            pipe[0] <= rd_now;
            for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
            if (env_clr) begin
                for (int i = 0; i < 64; i++) env_vld[i] <= 1'b0;
            end else if (mem_wr[g]) begin
                env_mem[mem_addr[g][7:2]] <= mem_din[g];
                env_vld[mem_addr[g][7:2]] <= 1'b1;
            end
        end

        assign mem_dout[g] = (lat_of(g) == 1) ? rd_now : pipe[PIX];

        mem_arbiter #(.MEM_LAT(lat_of(g))) u_dut (
            .CLK       (clk),
            .RESET     (rst),
            .IF_REQ    (if_req[g]),
            .IF_ADDR   (if_addr[g]),
            .IF_ACK    (if_ack[g]),
            .IF_RDATA  (if_rdata[g]),
            .DM_REQ    (dm_req[g]),
            .DM_WE     (dm_we[g]),
            .DM_ADDR   (dm_addr[g]),
            .DM_WDATA  (dm_wdata[g]),
            .DM_ACK    (dm_ack[g]),
            .DM_RDATA  (dm_rdata[g]),
            .MEM_ADDR  (mem_addr[g]),
            .MEM_WR    (mem_wr[g]),
            .MEM_DIN   (mem_din[g]),
            .MEM_DOUT  (mem_dout[g]),
            .BUSY      (busy[g]),
            .ARB_ESTADO(estado[g])
        );
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    logic saw_wait;

    // Reference memory contents for the random phase (addresses 0x80..0xFC only).
    logic [31:0] mdl_mem [3][64];
    logic        mdl_vld [3][64];

    function automatic logic [31:0] mrd(int k, logic [31:0] a);
        return mdl_vld[k][a[7:2]] ? mdl_mem[k][a[7:2]] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int k, input logic ir, input logic dr, input logic we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        if_req[k] = ir; dm_req[k] = dr; dm_we[k] = we;
        if_addr[k] = ia; dm_addr[k] = da; dm_wdata[k] = wd;
    endtask

    // Returns at a negedge with all instances idle and RESET low for the coming edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_in(k, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input int k, input string nm, input logic ir, input logic dr,
                           input logic we, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic exp_dm, input int exp_cyc,
                           input logic [31:0] exp_ird, input logic [31:0] exp_drd);
        int   ack_at;
        int   wr_cnt;
        logic got_dm;
        ack_at = -1; wr_cnt = 0; got_dm = 1'b0; saw_wait = 1'b0;
        set_in(k, ir, dr, we, ia, da, wd);
        for (int n = 1; n <= 12 && ack_at < 0; n++) begin
            @(negedge clk);
            chk({nm, "_ack_excl"}, 32'(if_ack[k] & dm_ack[k]), 32'd0);
            if (mem_wr[k]) begin
                wr_cnt++;
                chk({nm, "_wr_cycle"}, 32'(n), 32'd1);
                chk({nm, "_wr_addr"}, mem_addr[k], da);
                chk({nm, "_wr_din"}, mem_din[k], wd);
            end
            if (estado[k] == 2'd2) saw_wait = 1'b1;
            if (if_ack[k] | dm_ack[k]) begin
                ack_at = n;
                got_dm = dm_ack[k];
            end
        end
        set_in(k, 0, 0, 0, 0, 0, 0);
        chk({nm, "_ack_cycle"}, 32'(ack_at), 32'(exp_cyc));
        chk({nm, "_ack_port"}, 32'(got_dm), 32'(exp_dm));
        chk({nm, "_if_rdata"}, if_rdata[k], exp_ird);
        chk({nm, "_dm_rdata"}, dm_rdata[k], exp_drd);
        chk({nm, "_wr_count"}, 32'(wr_cnt), 32'(dr & we & exp_dm));
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy[k]), 32'd0);
    endtask

    typedef struct {
        logic        ir, dr, we;
        logic [31:0] ia, da, wd;
        logic        exp_dm;
        int          exp_cyc;
        logic [31:0] exp_ird, exp_drd;
    } vec_t;

    task automatic rand_phase(input int k, input int cycles);
        int unsigned lat;
        logic        tv, tg, twe, last, ir, dr, we, r;
        int          ts, ta;
        logic [31:0] taddr, twd, eird, edrd, ia, da, wd;
        logic [1:0]  code;
        string       p;
        lat = lat_of(k);
        p = $sformatf("rnd%0d", k);
        tv = 0; tg = 0; twe = 0; last = 1'b1; ts = 0; ta = 0;
        taddr = 0; twd = 0; eird = 0; edrd = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (c > 0) @(negedge clk);
            if (tv && c > ta) tv = 0;
            if (tv && c == ta && !twe) begin
                if (tg) edrd = mrd(k, taddr);
                else    eird = mrd(k, taddr);
            end
            code = !tv ? 2'd0 : (c == ts + 1) ? 2'd1 : (c == ta) ? 2'd3 : 2'd2;
            chk({p, "_estado"}, 32'(estado[k]), 32'(code));
            chk({p, "_busy"}, 32'(busy[k]), 32'(tv));
            chk({p, "_if_ack"}, 32'(if_ack[k]), 32'(tv && c == ta && !tg));
            chk({p, "_dm_ack"}, 32'(dm_ack[k]), 32'(tv && c == ta && tg));
            chk({p, "_mem_wr"}, 32'(mem_wr[k]), 32'(tv && c == ts + 1 && twe));
            chk({p, "_if_rdata"}, if_rdata[k], eird);
            chk({p, "_dm_rdata"}, dm_rdata[k], edrd);
            if (tv && c < ta) chk({p, "_mem_addr"}, mem_addr[k], taddr);
            if (tv && c == ts + 1 && twe) chk({p, "_mem_din"}, mem_din[k], twd);

            r  = ($urandom_range(0, 59) == 0);
            ir = $urandom_range(0, 1) == 1;
            dr = $urandom_range(0, 1) == 1;
            we = $urandom_range(0, 1) == 1;
            wd = $urandom;
            if (tv) begin
                ia = $urandom; da = $urandom;
            end else begin
                ia = 32'h80 | ($urandom & 32'h7C);
                da = 32'h80 | ($urandom & 32'h7C);
            end
            rst = r;
            set_in(k, ir, dr, we, ia, da, wd);

            if (r) begin
                tv = 0; last = 1'b1; eird = 0; edrd = 0;
            end else begin
                if (tv && c == ts + 1 && twe) begin
                    mdl_mem[k][taddr[7:2]] = twd;
                    mdl_vld[k][taddr[7:2]] = 1'b1;
                end
                if (!tv && (ir || dr)) begin
                    tg    = (ir && dr) ? !last : dr;
                    last  = tg;
                    twe   = tg && we;
                    taddr = tg ? da : ia;
                    twd   = wd;
                    ts    = c;
                    ta    = c + (twe ? 2 : int'(lat) + 1);
                    tv    = 1;
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        set_in(k, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int   acks, first, second;
        logic ord [4];

        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 64; w++) begin
                mdl_mem[k][w] = 32'd0;
                mdl_vld[k][w] = 1'b0;
            end
        rst = 1'b1;
        env_clr = 1'b1;
        for (int k = 0; k < 3; k++) set_in(k, 0, 0, 0, 0, 0, 0);
        do_reset();
        env_clr = 1'b0;

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_if_ack", k), 32'(if_ack[k]), 32'd0);
            chk($sformatf("rst%0d_dm_ack", k), 32'(dm_ack[k]), 32'd0);
            chk($sformatf("rst%0d_if_rdata", k), if_rdata[k], 32'd0);
            chk($sformatf("rst%0d_dm_rdata", k), dm_rdata[k], 32'd0);
            chk($sformatf("rst%0d_mem_addr", k), mem_addr[k], 32'd0);
            chk($sformatf("rst%0d_mem_wr", k), 32'(mem_wr[k]), 32'd0);
            chk($sformatf("rst%0d_mem_din", k), mem_din[k], 32'd0);
            chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst%0d_estado", k), 32'(estado[k]), 32'd0);
        end

        // Directed table on the MEM_LAT=2 instance, starting with LAST_GNT = DM.
        //          ir dr we  ia      da      wd            dm cyc ird           drd
        tbl[0] = '{1, 0, 0, 32'h04, 32'h00, 32'h0,        0, 3, 32'h00A00093, 32'h0};
        tbl[1] = '{0, 1, 1, 32'h00, 32'h40, 32'hDEADBEEF, 1, 2, 32'h00A00093, 32'h0};
        tbl[2] = '{0, 1, 0, 32'h00, 32'h40, 32'h0,        1, 3, 32'h00A00093, 32'hDEADBEEF};
        tbl[3] = '{1, 1, 1, 32'h08, 32'h44, 32'h12345678, 0, 3, 32'hC0DE0008, 32'hDEADBEEF};
        tbl[4] = '{0, 1, 0, 32'h00, 32'h44, 32'h0,        1, 3, 32'hC0DE0008, 32'hC0DE0044};
        tbl[5] = '{1, 1, 1, 32'h0C, 32'h44, 32'h12345678, 0, 3, 32'hC0DE000C, 32'hC0DE0044};
        tbl[6] = '{1, 1, 1, 32'h10, 32'h44, 32'h12345678, 1, 2, 32'hC0DE000C, 32'hC0DE0044};
        tbl[7] = '{0, 1, 0, 32'h00, 32'h44, 32'h0,        1, 3, 32'hC0DE000C, 32'h12345678};
        for (int i = 0; i < 8; i++)
            run_txn(1, $sformatf("row%0d", i), tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].ia,
                    tbl[i].da, tbl[i].wd, tbl[i].exp_dm, tbl[i].exp_cyc, tbl[i].exp_ird,
                    tbl[i].exp_drd);

        // Both requests held from reset release: IF, DM, IF, DM.
        do_reset();
        set_in(1, 1, 1, 0, 32'h14, 32'h18, 32'h0);
        acks = 0;
        for (int i = 0; i < 4; i++) ord[i] = 1'bx;
        for (int n = 1; n <= 40 && acks < 4; n++) begin
            @(negedge clk);
            chk("alt_ack_excl", 32'(if_ack[1] & dm_ack[1]), 32'd0);
            if (if_ack[1] | dm_ack[1]) begin
                ord[acks] = dm_ack[1];
                acks++;
            end
        end
        set_in(1, 0, 0, 0, 0, 0, 0);
        chk("alt_ack_count", 32'(acks), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("alt_order%0d", i), 32'(ord[i]), 32'(i % 2));
        chk("alt_if_rdata", if_rdata[1], 32'hC0DE0014);
        chk("alt_dm_rdata", dm_rdata[1], 32'hC0DE0018);
        @(negedge clk);

        // Reset at the capture edge of a DM read: aborted, no ACK, RDATA cleared.
        set_in(1, 0, 1, 0, 32'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("abort_access", 32'(estado[1]), 32'd1);
        @(negedge clk);
        chk("abort_wait", 32'(estado[1]), 32'd2);
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_estado", 32'(estado[1]), 32'd0);
        chk("abort_busy", 32'(busy[1]), 32'd0);
        chk("abort_dm_rdata", dm_rdata[1], 32'd0);
        for (int n = 0; n < 4; n++) begin
            chk("abort_no_ack", 32'(dm_ack[1]), 32'd0);
            @(negedge clk);
        end

        // Reset during the ACCESS cycle of a store must suppress MEM_WR at once.
        set_in(1, 0, 1, 1, 32'h0, 32'h4C, 32'h11112222);
        @(negedge clk);
        chk("mask_wr_before", 32'(mem_wr[1]), 32'd1);
        rst = 1'b1;
        #1;
        chk("mask_wr_during", 32'(mem_wr[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0);
        chk("mask_estado", 32'(estado[1]), 32'd0);
        run_txn(1, "mask_rd", 0, 1, 0, 32'h0, 32'h4C, 32'h0, 1, 3, 32'h0, 32'hC0DE004C);

        // IF_REQ held through the IDLE cycle after IF_ACK starts a second fetch.
        set_in(1, 1, 0, 0, 32'h04, 32'h0, 32'h0);
        acks = 0; first = -1; second = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (if_ack[1]) begin
                if (acks == 0) first = n;
                else           second = n;
                acks++;
            end
            if (acks == 1 && n == first + 2) if_req[1] = 1'b0;
        end
        chk("hold_ack_count", 32'(acks), 32'd2);
        chk("hold_first", 32'(first), 32'd3);
        chk("hold_second", 32'(second - first), 32'd4);
        chk("hold_if_rdata", if_rdata[1], 32'h00A00093);

        // Latency sweep on MEM_LAT=1 and MEM_LAT=7.
        do_reset();
        run_txn(0, "lat1_rd", 1, 0, 0, 32'h04, 32'h0, 32'h0, 0, 2, 32'h00A00093, 32'h0);
        chk("lat1_no_wait", 32'(saw_wait), 32'd0);
        run_txn(0, "lat1_wr", 0, 1, 1, 32'h0, 32'h48, 32'h5555AAAA, 1, 2, 32'h00A00093, 32'h0);
        run_txn(0, "lat1_rd2", 0, 1, 0, 32'h0, 32'h48, 32'h0, 1, 2, 32'h00A00093, 32'h5555AAAA);
        run_txn(2, "lat7_rd", 0, 1, 0, 32'h0, 32'h40, 32'h0, 1, 8, 32'h0, 32'hC0DE0040);
        chk("lat7_wait", 32'(saw_wait), 32'd1);
        run_txn(2, "lat7_wr", 0, 1, 1, 32'h0, 32'h48, 32'hCAFEF00D, 1, 2, 32'h0, 32'hC0DE0040);
        run_txn(2, "lat7_rd2", 0, 1, 0, 32'h0, 32'h48, 32'h0, 1, 8, 32'h0, 32'hCAFEF00D);
        run_txn(2, "lat7_if", 1, 0, 0, 32'h04, 32'h0, 32'h0, 0, 8, 32'h00A00093, 32'hCAFEF00D);

        for (int k = 0; k < 3; k++) rand_phase(k, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles from address presented to MEM_DOUT valid; legal range 1..7.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 IF_REQ  input  1  instruction-fetch read request, held high until IF_ACK.
REQ-005 IF_ADDR  input  32  fetch address, stable while IF_REQ is high.
REQ-006 IF_ACK  output  1  one-cycle pulse: fetch complete, IF_RDATA valid.
REQ-007 IF_RDATA  output  32  registered fetch data.
REQ-008 DM_REQ  input  1  data-access request (LD/SD), held high until DM_ACK.
REQ-009 DM_WE  input  1  1 = write, 0 = read; stable while DM_REQ is high.
REQ-010 DM_ADDR  input  32  data address.
REQ-011 DM_WDATA  input  32  store data.
REQ-012 DM_ACK  output  1  one-cycle pulse: data access complete.
REQ-013 DM_RDATA  output  32  registered load data.
REQ-014 MEM_ADDR  output  32  address to the single-port memory.
REQ-015 MEM_WR  output  1  memory write strobe.
REQ-016 MEM_DIN  output  32  memory write data.
REQ-017 MEM_DOUT  input  32  memory read data.
REQ-018 BUSY  output  1  high whenever the state is not IDLE.
REQ-019 ARB_ESTADO  output  2  current state code: IDLE=0, ACCESS=1, WAIT=2, DONE=3.

Function
REQ-020 The FSM SHALL use the states IDLE, ACCESS, WAIT and DONE, with all outputs decoded from the registered state and the latched transaction.
REQ-021 In IDLE, at an edge with any REQ high, the block SHALL latch the grant (GNT), address, DM_WE (forced 0 for an IF grant) and DM_WDATA, then go to ACCESS; with no REQ high it SHALL stay in IDLE.
REQ-022 Arbitration on a tie: grant the requester not granted last, tracked by register LAST_GNT; reset value = DM, so IF wins the first tie.
REQ-023 With a single requester, that requester SHALL be granted regardless of LAST_GNT; LAST_GNT updates on every grant.
REQ-024 ACCESS lasts 1 cycle: MEM_ADDR = latched address, MEM_DIN = latched wdata, MEM_WR = latched WE.
REQ-025 On a write, ACCESS SHALL go to DONE.
REQ-026 On a read with MEM_LAT=1, ACCESS SHALL go to DONE and capture MEM_DOUT at that edge.
REQ-027 On a read with MEM_LAT>1, ACCESS SHALL go to WAIT and load a 3-bit counter with MEM_LAT-2.
REQ-028 In WAIT, MEM_ADDR SHALL be held and MEM_WR SHALL be 0; the counter decrements each cycle, and at the edge where it is 0 the FSM SHALL capture MEM_DOUT into the granted port's RDATA and go to DONE.
REQ-029 In DONE, the block SHALL assert exactly one ACK (the granted port) for 1 cycle, then return to IDLE.
REQ-030 Latency: with REQ first sampled in IDLE in cycle 0, the ACK SHALL be high in cycle MEM_LAT+1 for a read and in cycle 2 for a write.
REQ-031 Each RDATA register SHALL hold its value until that port's next read completes; writes SHALL not change DM_RDATA.
REQ-032 A requester SHALL drop REQ in the cycle after its ACK; a REQ still high in IDLE SHALL be served as a new transaction.
REQ-033 REQ or address changes while not in IDLE SHALL be ignored; no pre-emption is allowed.
REQ-034 MEM_WR SHALL be combinationally masked by RESET so that no write occurs in a reset cycle.
REQ-035 When the state is not ACCESS, MEM_WR SHALL be 0, and IF_ACK and DM_ACK SHALL never be high together.

Reset
REQ-036 RESET high at an edge, from any state, SHALL force IDLE and discard any in-flight transaction, with no ACK issued.
REQ-037 Reset SHALL clear LAST_GNT to DM and the counter to 0.
REQ-038 After reset, all outputs SHALL be 0: IF_ACK, DM_ACK, IF_RDATA, DM_RDATA, MEM_ADDR, MEM_WR, MEM_DIN, BUSY, ARB_ESTADO.
REQ-039 Both requests high in the first cycle after reset SHALL result in an IF grant.

Verification
REQ-040 MEM_LAT=2, IF_REQ with IF_ADDR=0x00000004, memory returns 0x00A00093 -> IF_ACK in cycle 3, IF_RDATA=0x00A00093, MEM_WR=0 throughout.
REQ-041 DM_REQ with DM_WE=1, DM_ADDR=0x40, DM_WDATA=0xDEADBEEF -> MEM_WR=1 only in cycle 1 with MEM_ADDR=0x40 and MEM_DIN=0xDEADBEEF, DM_ACK in cycle 2, DM_RDATA unchanged.
REQ-042 IF_REQ and DM_REQ both held from reset release -> grant order IF, DM, IF, DM, with alternating ACKs and no cycle where both ACKs are high.
REQ-043 RESET asserted in WAIT of a DM read -> next state IDLE, no DM_ACK, DM_RDATA=0, BUSY=0.
REQ-044 MEM_LAT=1 and MEM_LAT=7 read sweeps -> ACK in cycle 2 and cycle 8 respectively, with WAIT skipped when MEM_LAT=1.
REQ-045 IF_REQ held high one cycle past its IF_ACK -> a second fetch is served and a second IF_ACK is issued.
